vip_bin_morph_3x3: RTL and testbench

3×3 binary morphology stage that consumes the 1-bit edge stream from the Sobel edge detector. It performs erosion or dilation on the `pre_*` vsync/href/clken video stream and emits a cleaned 1-bit `post_*` stream with identical framing. It contains two line buffers and a 3×3 window register, and sits between the Sobel stage and the frame-capture logic.

---
 rtl/vip_bin_morph_3x3.sv | 128 ++++++++++++
 tb/tb_vip_bin_morph_3x3.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vip_bin_morph_3x3.sv
// 3x3 binary erosion (MODE=0) or dilation (MODE=1) on a 1-bit vsync/href/clken stream.
// Two line buffers feed a registered 3x3 window; the result trails the input by 2 clocks.
module vip_bin_morph_3x3 #(
  parameter int IMG_HDISP = 400,
  parameter int IMG_VDISP = 400,
  parameter int MODE      = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pre_frame_vsync,
  input  logic pre_frame_href,
  input  logic pre_frame_clken,
  input  logic pre_img_Bit,
  output logic post_frame_vsync,
  output logic post_frame_href,
  output logic post_frame_clken,
  output logic post_img_Bit
);
  localparam int              XW    = $clog2(IMG_HDISP + 1);
  localparam int              YW    = $clog2(IMG_VDISP + 1);
  localparam int              AW    = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam logic            PAD   = (MODE == 0) ? 1'b1 : 1'b0;
  localparam logic [XW-1:0]   X_MAX = XW'(IMG_HDISP);
  localparam logic [YW-1:0]   Y_MAX = YW'(IMG_VDISP);

  function automatic logic morph_reduce(input logic [8:0] taps);
    if (MODE == 0) return &taps;
    return |taps;
  endfunction

  // Stage p0: pixel acceptance, column/row position, line-buffer taps
  logic [XW-1:0] x_p0;
  logic [YW-1:0] y_p0;
  logic          href_prev;
  logic          acc_p0;
  logic [AW-1:0] addr_p0;
  logic [2:0]    col_p0;

  logic lb_a [IMG_HDISP];
  logic lb_b [IMG_HDISP];

  assign acc_p0  = pre_frame_href & pre_frame_clken & (x_p0 < X_MAX);
  assign addr_p0 = x_p0[AW-1:0];

  // Rows above the frame top read as PAD, which also hides stale buffer data
  assign col_p0 = {((int'(y_p0) < 2) ? PAD : lb_b[addr_p0]),
                   ((int'(y_p0) < 1) ? PAD : lb_a[addr_p0]),
                   pre_img_Bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_p0 <= '0;
    end else if (!pre_frame_href) begin
      x_p0 <= '0;
    end else if (acc_p0) begin
      x_p0 <= x_p0 + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p0      <= '0;
      href_prev <= 1'b0;
    end else begin
      href_prev <= pre_frame_href;
      if (!pre_frame_vsync) begin
        y_p0 <= '0;
      end else if (href_prev && !pre_frame_href && (y_p0 < Y_MAX)) begin
        y_p0 <= y_p0 + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc_p0) begin
      lb_b[addr_p0] <= lb_a[addr_p0];
      lb_a[addr_p0] <= pre_img_Bit;
    end
  end

  // Stage p1: 3x3 window, column [0] is the newest
  logic [2:0][2:0] win_p1;
  logic            vsync_p1;
  logic            href_p1;
  logic            vld_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_p1 <= {9{PAD}};
    end else if (!pre_frame_href) begin
      win_p1 <= {9{PAD}};
    end else if (acc_p0) begin
      win_p1 <= {win_p1[1:0], col_p0};
    end
  end

  // Stage p2: registered operator result and aligned framing
  logic vsync_p2;
  logic href_p2;
  logic vld_p2;
  logic bit_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_p1 <= 1'b0;
      href_p1  <= 1'b0;
      vld_p1   <= 1'b0;
      vsync_p2 <= 1'b0;
      href_p2  <= 1'b0;
      vld_p2   <= 1'b0;
      bit_p2   <= 1'b0;
    end else begin
      vsync_p1 <= pre_frame_vsync;
      href_p1  <= pre_frame_href;
      vld_p1   <= pre_frame_clken;
      vsync_p2 <= vsync_p1;
      href_p2  <= href_p1;
      vld_p2   <= vld_p1;
      bit_p2   <= morph_reduce(win_p1);
    end
  end

  assign post_frame_vsync = vsync_p2;
  assign post_frame_href  = href_p2;
  assign post_frame_clken = vld_p2;
  assign post_img_Bit     = bit_p2;

endmodule

// File: tb/tb_vip_bin_morph_3x3.sv
// Bench for vip_bin_morph_3x3: an erosion and a dilation instance share one input stream;
// captured output frames are compared with a spatial reference model and hand-computed probes.
module tb_vip_bin_morph_3x3;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int WL = W + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pre_vsync = 1'b0;
  logic pre_href = 1'b0;
  logic pre_clken = 1'b0;
  logic pre_bit = 1'b0;
  logic [1:0] post_vsync, post_href, post_clken, post_bit;

  vip_bin_morph_3x3 #(.IMG_HDISP(W), .IMG_VDISP(H), .MODE(0)) dut_ero (
    .clk(clk), .rst_n(rst_n),
    .pre_frame_vsync(pre_vsync), .pre_frame_href(pre_href),
    .pre_frame_clken(pre_clken), .pre_img_Bit(pre_bit),
    .post_frame_vsync(post_vsync[0]), .post_frame_href(post_href[0]),
    .post_frame_clken(post_clken[0]), .post_img_Bit(post_bit[0])
  );

  vip_bin_morph_3x3 #(.IMG_HDISP(W), .IMG_VDISP(H), .MODE(1)) dut_dil (
    .clk(clk), .rst_n(rst_n),
    .pre_frame_vsync(pre_vsync), .pre_frame_href(pre_href),
    .pre_frame_clken(pre_clken), .pre_img_Bit(pre_bit),
    .post_frame_vsync(post_vsync[1]), .post_frame_href(post_href[1]),
    .post_frame_clken(post_clken[1]), .post_img_Bit(post_bit[1])
  );

  always #5 clk = ~clk;

  typedef struct {
    int pat;
    int m;
    int x;
    int y;
    bit exp;
  } probe_t;

  probe_t     probes[$];
  bit         in_img [H][WL];
  logic [1:0] cap [2][H][W];
  int         ox [2];
  int         oy [2];
  logic       prev_h [2];
  logic       h1, h2, v1, v2, c1, c2;
  bit         chk_ctrl = 1'b0;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model(input int m, input int x, input int y);
    bit pad = (m == 0);
    bit r = pad;
    for (int dy = 0; dy < 3; dy++) begin
      for (int dx = 0; dx < 3; dx++) begin
        bit v;
        v = (x - dx < 0 || y - dy < 0) ? pad : in_img[y - dy][x - dx];
        r = (m == 0) ? (r & v) : (r | v);
      end
    end
    return r;
  endfunction

  // Reference history for the 2-cycle framing delay
  always @(posedge clk) begin
    h1 <= pre_href;  h2 <= h1;
    v1 <= pre_vsync; v2 <= v1;
    c1 <= pre_clken; c2 <= c1;
  end

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (!post_vsync[m]) begin
        ox[m] = 0;
        oy[m] = 0;
      end else begin
        if (post_href[m] && post_clken[m]) begin
          if (ox[m] < W && oy[m] < H) cap[m][oy[m]][ox[m]] = {1'b0, post_bit[m]};
          ox[m]++;
        end
        if (!post_href[m]) begin
          ox[m] = 0;
          if (prev_h[m] === 1'b1) oy[m]++;
        end
      end
      prev_h[m] = post_href[m];
      if (chk_ctrl) begin
        check($sformatf("ctrl href m%0d", m), post_href[m], h2);
        check($sformatf("ctrl vsync m%0d", m), post_vsync[m], v2);
        check($sformatf("ctrl clken m%0d", m), post_clken[m], c2);
      end
    end
  end

  task automatic fill(input int pat);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < WL; x++) begin
        case (pat)
          0:       in_img[y][x] = 1'b1;
          1:       in_img[y][x] = (x == 3 && y == 2);
          2:       in_img[y][x] = !(x == 4 && y == 3);
          3:       in_img[y][x] = 1'b0;
          default: in_img[y][x] = 1'($urandom_range(0, 1));
        endcase
      end
    end
  endtask

  task automatic pix_cycle(input logic h, input logic ce, input logic d);
    pre_href  = h;
    pre_clken = ce;
    pre_bit   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("midrst vsync m%0d", m), post_vsync[m], 0);
      check($sformatf("midrst href m%0d", m), post_href[m], 0);
      check($sformatf("midrst clken m%0d", m), post_clken[m], 0);
      check($sformatf("midrst bit m%0d", m), post_bit[m], 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input bit gaps, input int long_row, input int rst_row);
    for (int m = 0; m < 2; m++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) cap[m][y][x] = 2'd2;
    pre_vsync = 1'b0;
    repeat (4) pix_cycle(1'b0, 1'b0, 1'b0);
    pre_vsync = 1'b1;
    repeat (3) pix_cycle(1'b0, 1'b0, 1'b0);
    for (int y = 0; y < H; y++) begin
      int n;
      n = (y == long_row) ? WL : W;
      for (int x = 0; x < n; x++) begin
        if (y == rst_row && x == 3) reset_pulse();
        if (gaps && (x % 2 == 1)) pix_cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        pix_cycle(1'b1, 1'b1, in_img[y][x]);
      end
      repeat (3) pix_cycle(1'b0, 1'b0, 1'b0);
    end
    pre_vsync = 1'b0;
    repeat (4) pix_cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_frame(input string tag);
    for (int m = 0; m < 2; m++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          check($sformatf("%s m%0d (%0d,%0d)", tag, m, x, y), cap[m][y][x], model(m, x, y));
  endtask

  task automatic check_probes(input int pat);
    foreach (probes[i]) begin
      if (probes[i].pat == pat)
        check($sformatf("probe p%0d m%0d (%0d,%0d)", pat, probes[i].m, probes[i].x, probes[i].y),
              cap[probes[i].m][probes[i].y][probes[i].x], probes[i].exp);
    end
  endtask

  initial begin
    probes = '{
      '{0, 0, 0, 0, 1'b1}, '{0, 0, 7, 5, 1'b1}, '{0, 1, 0, 0, 1'b1},
      '{1, 1, 3, 2, 1'b1}, '{1, 1, 5, 4, 1'b1}, '{1, 1, 4, 3, 1'b1}, '{1, 1, 5, 2, 1'b1},
      '{1, 1, 3, 4, 1'b1}, '{1, 1, 2, 2, 1'b0}, '{1, 1, 6, 3, 1'b0}, '{1, 1, 3, 1, 1'b0},
      '{1, 1, 4, 5, 1'b0}, '{1, 1, 0, 0, 1'b0}, '{1, 0, 0, 0, 1'b0},
      '{2, 0, 4, 3, 1'b0}, '{2, 0, 6, 5, 1'b0}, '{2, 0, 5, 4, 1'b0}, '{2, 0, 3, 3, 1'b1},
      '{2, 0, 7, 3, 1'b1}, '{2, 0, 4, 2, 1'b1}, '{2, 0, 0, 0, 1'b1}, '{2, 0, 0, 3, 1'b1},
      '{2, 0, 7, 5, 1'b1}, '{2, 1, 0, 0, 1'b1},
      '{3, 1, 0, 0, 1'b0}, '{3, 1, 7, 5, 1'b0}, '{3, 1, 4, 3, 1'b0}
    };

    // Reset state with all inputs held high
    rst_n = 1'b0;
    pre_vsync = 1'b1; pre_href = 1'b1; pre_clken = 1'b1; pre_bit = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("reset vsync m%0d", m), post_vsync[m], 0);
      check($sformatf("reset href m%0d", m), post_href[m], 0);
      check($sformatf("reset clken m%0d", m), post_clken[m], 0);
      check($sformatf("reset bit m%0d", m), post_bit[m], 0);
    end
    pre_vsync = 1'b0; pre_href = 1'b0; pre_clken = 1'b0; pre_bit = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    fill(0);
    chk_ctrl = 1'b1;
    send_frame(1'b0, -1, -1);
    chk_ctrl = 1'b0;
    check_frame("allones");
    check_probes(0);

    fill(1);
    send_frame(1'b0, -1, -1);
    check_frame("pixel");
    check_probes(1);

    fill(2);
    send_frame(1'b0, -1, -1);
    check_frame("hole");
    check_probes(2);

    fill(3);
    send_frame(1'b0, -1, -1);
    check_frame("stale");
    check_probes(3);

    fill(4);
    send_frame(1'b1, 3, -1);
    check_frame("gaps");

    fill(5);
    send_frame(1'b0, -1, 2);
    send_frame(1'b0, -1, -1);
    check_frame("postrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
